pipeline_stall_controller: RTL and testbench

//  Consumes the load-use hazard flag, branch-taken flag and both memory busywaits.

---
 rtl/pipeline_stall_controller_pkg.sv | 31 +++
 rtl/pipeline_stall_controller_sat_counter.sv | 41 ++++
 rtl/pipeline_stall_controller.sv | 123 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// ============================================================================
// pipeline_stall_controller_pkg : shared state encoding and control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_stall_controller_pkg;

    localparam int CNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_BUBBLE = 2'd1,
        ST_DMEM_WAIT = 2'd2,
        ST_IMEM_WAIT = 2'd3
    } stall_state_e;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic id_ex_hold;
        logic ex_mem_hold;
        logic mem_wb_hold;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pc_use_saved_tgt;
    } pipe_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
// ============================================================================
// pipeline_stall_controller_sat_counter : saturating up-counter, sync clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// pipeline_stall_controller : stall/flush/bubble control for a 5-stage pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lu_haz_sig_i,
    input  logic                 ex_branch_taken_i,
    input  logic                 imem_busywait_i,
    input  logic                 dmem_busywait_i,
    input  logic                 cnt_clear_i,
    output logic                 pc_hold_o,
    output logic                 if_id_hold_o,
    output logic                 id_ex_hold_o,
    output logic                 ex_mem_hold_o,
    output logic                 mem_wb_hold_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_bubble_o,
    output logic                 pc_use_saved_tgt_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] lu_bubble_count_o
);

    stall_state_e state_q, state_d;
    logic         squash_q, squash_d;
    logic         active_q;
    logic         lu_ins;
    pipe_ctrl_t   ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            squash_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            active_q <= 1'b1;
        end
    end

    // The first cycle out of reset is held quiet: no controls, no state change.
    always_comb begin
        ctrl     = '0;
        state_d  = state_q;
        squash_d = squash_q;
        lu_ins   = 1'b0;
        if (active_q) begin
            if (dmem_busywait_i) begin
                ctrl.pc_hold     = 1'b1;
                ctrl.if_id_hold  = 1'b1;
                ctrl.id_ex_hold  = 1'b1;
                ctrl.ex_mem_hold = 1'b1;
                ctrl.mem_wb_hold = 1'b1;
                state_d          = ST_DMEM_WAIT;
            end else if (imem_busywait_i) begin
                ctrl.pc_hold      = 1'b1;
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_bubble = ex_branch_taken_i;
                if (ex_branch_taken_i) begin
                    squash_d = 1'b1;
                end
                state_d = ST_IMEM_WAIT;
            end else begin
                state_d = ST_RUN;
                // A branch squashed during a fetch stall redirects once fetch resumes.
                if (squash_q) begin
                    ctrl.if_id_flush      = 1'b1;
                    ctrl.pc_use_saved_tgt = 1'b1;
                    squash_d              = 1'b0;
                end else if (ex_branch_taken_i) begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (lu_haz_sig_i && (state_q != ST_LU_BUBBLE)) begin
                    ctrl.pc_hold      = 1'b1;
                    ctrl.if_id_hold   = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                    lu_ins            = 1'b1;
                    state_d           = ST_LU_BUBBLE;
                end
            end
        end
    end

    assign pc_hold_o          = ctrl.pc_hold;
    assign if_id_hold_o       = ctrl.if_id_hold;
    assign id_ex_hold_o       = ctrl.id_ex_hold;
    assign ex_mem_hold_o      = ctrl.ex_mem_hold;
    assign mem_wb_hold_o      = ctrl.mem_wb_hold;
    assign if_id_flush_o      = ctrl.if_id_flush;
    assign id_ex_bubble_o     = ctrl.id_ex_bubble;
    assign pc_use_saved_tgt_o = ctrl.pc_use_saved_tgt;

    pipeline_stall_controller_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (ctrl.pc_hold),
        .clr_i   (cnt_clear_i),
        .count_o (stall_count_o)
    );

    pipeline_stall_controller_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_lu_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (lu_ins),
        .clr_i   (cnt_clear_i),
        .count_o (lu_bubble_count_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// ============================================================================
// tb_pipeline_stall_controller : directed + random bench against a flag model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_controller;

    localparam int W    = 4;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lu = 1'b0, br = 1'b0, im = 1'b0, dm = 1'b0, clr = 1'b0;
    logic         pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold;
    logic         if_id_flush, id_ex_bubble, pc_use_saved_tgt;
    logic [W-1:0] stall_count, lu_bubble_count;

    int total = 0;
    int bad   = 0;

    // Reference model: quiet first cycle, one-bubble guard, pending squash, counts.
    bit       m_first, m_after_bubble, m_squash;
    int       m_stall, m_lu;
    logic [7:0] exp_ctrl;
    bit       exp_lu_ins;

    pipeline_stall_controller #(.CNT_WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lu_haz_sig_i       (lu),
        .ex_branch_taken_i  (br),
        .imem_busywait_i    (im),
        .dmem_busywait_i    (dm),
        .cnt_clear_i        (clr),
        .pc_hold_o          (pc_hold),
        .if_id_hold_o       (if_id_hold),
        .id_ex_hold_o       (id_ex_hold),
        .ex_mem_hold_o      (ex_mem_hold),
        .mem_wb_hold_o      (mem_wb_hold),
        .if_id_flush_o      (if_id_flush),
        .id_ex_bubble_o     (id_ex_bubble),
        .pc_use_saved_tgt_o (pc_use_saved_tgt),
        .stall_count_o      (stall_count),
        .lu_bubble_count_o  (lu_bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
                if_id_flush, id_ex_bubble, pc_use_saved_tgt};
    endfunction

    // Bit order: pc, if_id, id_ex, ex_mem, mem_wb holds, flush, bubble, saved target.
    task automatic model_outputs();
        exp_ctrl   = 8'h00;
        exp_lu_ins = 1'b0;
        if (m_first)                     exp_ctrl = 8'h00;
        else if (dm)                     exp_ctrl = 8'b1111_1000;
        else if (im)                     exp_ctrl = {1'b1, 4'b0000, 1'b1, br, 1'b0};
        else if (m_squash)               exp_ctrl = 8'b0000_0101;
        else if (br)                     exp_ctrl = 8'b0000_0110;
        else if (lu && !m_after_bubble) begin
            exp_ctrl   = 8'b1100_0010;
            exp_lu_ins = 1'b1;
        end
    endtask

    task automatic model_update();
        if (!m_first) begin
            if (!dm) begin
                if (im)            m_squash = m_squash | br;
                else if (m_squash) m_squash = 1'b0;
            end
            m_after_bubble = exp_lu_ins;
        end
        m_first = 1'b0;
        if (clr) begin
            m_stall = 0;
            m_lu    = 0;
        end else begin
            if (exp_ctrl[7] && m_stall < MAXC) m_stall++;
            if (exp_lu_ins && m_lu < MAXC)     m_lu++;
        end
    endtask

    task automatic model_reset();
        m_first        = 1'b1;
        m_after_bubble = 1'b0;
        m_squash       = 1'b0;
        m_stall        = 0;
        m_lu           = 0;
    endtask

    // Called just after a rising edge; checks mid-cycle and returns after the next edge.
    task automatic cycle(input bit a_lu, input bit a_br, input bit a_im, input bit a_dm, input bit a_clr);
        lu = a_lu; br = a_br; im = a_im; dm = a_dm; clr = a_clr;
        model_outputs();
        @(negedge clk);
        check("ctrl", {24'h0, dut_ctrl()}, {24'h0, exp_ctrl});
        check("stall_cnt", {28'h0, stall_count}, m_stall);
        check("lu_cnt", {28'h0, lu_bubble_count}, m_lu);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        lu = 1'b1; br = 1'b1; dm = 1'b1; im = 1'b1;
        #1;
        check("reset_ctrl", {24'h0, dut_ctrl()}, 32'h0);
        check("reset_stall", {28'h0, stall_count}, 32'h0);
        check("reset_lu", {28'h0, lu_bubble_count}, 32'h0);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        clear_counts();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_single_cnt", {28'h0, lu_bubble_count}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        clear_counts();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_held_cnt", {28'h0, lu_bubble_count}, 32'd2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        clear_counts();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_br_stall", {28'h0, stall_count}, 32'd0);

        clear_counts();
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("dmem_stall4", {28'h0, stall_count}, 32'd4);
        check("dmem_no_bubble", {28'h0, lu_bubble_count}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        clear_counts();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        lu = 1'b0; br = 1'b0; im = 1'b0; dm = 1'b0;
        #1;
        check("squash_exit", {30'h0, if_id_flush, pc_use_saved_tgt}, 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("squash_once", {31'h0, pc_use_saved_tgt}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        clear_counts();
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("stall_sat", {28'h0, stall_count}, 32'd15);
        lu = 1'b1; dm = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_ctrl", {24'h0, dut_ctrl()}, 32'h0);
        check("midreset_stall", {28'h0, stall_count}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
